e_rx_block_ctrl: RTL

E_RX_BLOCK_CTRL -- requirements
Module: e_rx_block_ctrl

---
 rtl/e_rx_block_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/e_rx_block_ctrl.sv
// Receive-side block controller: paces host word reads against RX FIFO blocks.
// Optional macro E_RX_AUTO_STOP_EN adds the auto_cmd12 stop request after multi-block reads.
module e_rx_block_ctrl #(
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 xfer_start,
    input  logic                 xfer_abort,
    input  logic                 multi_blk,
    input  logic [11:0]          block_size_reg,
    input  logic [BLK_CNT_W-1:0] block_count_reg,
    input  logic                 buffer_read_en,
    input  logic                 host_rd,
    output logic                 pop,
    output logic                 rd_ready,
    output logic                 sd_rx_enable,
    output logic                 blk_done,
    output logic                 xfer_done,
    output logic [BLK_CNT_W-1:0] blk_remain,
    output logic                 busy,
    output logic                 size_err,
    output logic                 auto_cmd12
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        READ,
        BLK_END,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [11:0]          size_q, size_d;
    logic [11:0]          wcnt_q, wcnt_d;
    logic [BLK_CNT_W-1:0] remain_q, remain_d;
    logic                 rd_ready_q, rd_ready_d;
    logic                 sd_en_q, sd_en_d;
    logic                 busy_q, busy_d;
    logic                 blk_done_q, blk_done_d;
    logic                 xfer_done_q, xfer_done_d;
    logic                 size_err_q, size_err_d;
    logic [12:0]          size_p1;
    logic [11:0]          words;
    logic                 pop_ok;
`ifdef E_RX_AUTO_STOP_EN
    logic                 multi_q, multi_d;
    logic                 auto_q, auto_d;
`endif

    // Abort takes priority over a host read in the same cycle.
    assign pop_ok  = host_rd & rd_ready_q & ~xfer_abort;
    assign size_p1 = {1'b0, size_q} + 13'd1;
    assign words   = size_p1[12:1];

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        wcnt_d      = wcnt_q;
        remain_d    = remain_q;
        rd_ready_d  = rd_ready_q;
        sd_en_d     = sd_en_q;
        busy_d      = busy_q;
        blk_done_d  = 1'b0;
        xfer_done_d = 1'b0;
        size_err_d  = 1'b0;
`ifdef E_RX_AUTO_STOP_EN
        multi_d     = multi_q;
        auto_d      = 1'b0;
`endif
        if (state_q != IDLE && xfer_abort) begin
            state_d    = IDLE;
            wcnt_d     = '0;
            remain_d   = '0;
            rd_ready_d = 1'b0;
            sd_en_d    = 1'b0;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (xfer_start && !xfer_abort) begin
                        if (block_size_reg == 12'd0 ||
                            (multi_blk && block_count_reg == '0)) begin
                            size_err_d = 1'b1;
                        end else begin
                            state_d  = WAIT_BUF;
                            size_d   = block_size_reg;
                            remain_d = multi_blk ? block_count_reg
                                                 : BLK_CNT_W'(1);
                            busy_d   = 1'b1;
                            sd_en_d  = 1'b1;
`ifdef E_RX_AUTO_STOP_EN
                            multi_d  = multi_blk;
`endif
                        end
                    end
                end
                WAIT_BUF: begin
                    if (buffer_read_en) begin
                        state_d    = READ;
                        sd_en_d    = 1'b0;
                        rd_ready_d = 1'b1;
                        wcnt_d     = words;
                    end
                end
                READ: begin
                    if (pop_ok) begin
                        wcnt_d = wcnt_q - 12'd1;
                        if (wcnt_q == 12'd1) begin
                            state_d    = BLK_END;
                            rd_ready_d = 1'b0;
                            blk_done_d = 1'b1;
                            if (remain_q != '0)
                                remain_d = remain_q - BLK_CNT_W'(1);
                        end
                    end
                end
                BLK_END: begin
                    if (!buffer_read_en) begin
                        if (remain_q == '0) begin
                            state_d     = DONE;
                            xfer_done_d = 1'b1;
`ifdef E_RX_AUTO_STOP_EN
                            auto_d      = multi_q;
`endif
                        end else begin
                            state_d = WAIT_BUF;
                            sd_en_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            size_q      <= '0;
            wcnt_q      <= '0;
            remain_q    <= '0;
            rd_ready_q  <= 1'b0;
            sd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            blk_done_q  <= 1'b0;
            xfer_done_q <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            wcnt_q      <= wcnt_d;
            remain_q    <= remain_d;
            rd_ready_q  <= rd_ready_d;
            sd_en_q     <= sd_en_d;
            busy_q      <= busy_d;
            blk_done_q  <= blk_done_d;
            xfer_done_q <= xfer_done_d;
            size_err_q  <= size_err_d;
        end
    end

`ifdef E_RX_AUTO_STOP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_q <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            multi_q <= multi_d;
            auto_q  <= auto_d;
        end
    end

    assign auto_cmd12 = auto_q;
`else
    assign auto_cmd12 = 1'b0;
`endif

    assign pop          = pop_ok;
    assign rd_ready     = rd_ready_q;
    assign sd_rx_enable = sd_en_q;
    assign blk_done     = blk_done_q;
    assign xfer_done    = xfer_done_q;
    assign blk_remain   = remain_q;
    assign busy         = busy_q;
    assign size_err     = size_err_q;

endmodule
